// File: rtl/spi_slave_sync_if.sv
// Pin and host-side handshake bundle for spi_slave_sync; the slave modport faces the device.
interface spi_slave_sync_if #(parameter int DATA_W = 8);
    logic              sclk;
    logic              cs;
    logic              mosi;
    logic              miso;
    logic              miso_oe;
    logic [DATA_W-1:0] tx_data;
    logic              tx_load;
    logic              tx_ready;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              frame_err;
    logic              irq_req;
    logic              irq_out;

    modport slave (
        input  sclk, cs, mosi, tx_data, tx_load, irq_req,
        output miso, miso_oe, tx_ready, rx_data, rx_valid, frame_err, irq_out
    );

    modport master (
        output sclk, cs, mosi, tx_data, tx_load, irq_req,
        input  miso, miso_oe, tx_ready, rx_data, rx_valid, frame_err, irq_out
    );
endinterface

// File: rtl/spi_slave_sync.sv
// Oversampling SPI slave in the pclk domain: command-selected TX/RX word frames
// plus a queued interrupt frame that reports SLAVE_ADDR.
module spi_slave_sync #(
    parameter int          DATA_W     = 8,
    parameter bit          CPOL       = 1'b0,
    parameter bit          CPHA       = 1'b0,
    parameter bit          LSB_FIRST  = 1'b1,
    parameter logic [31:0] TX_RESET   = 32'hab,
    parameter logic [7:0]  SLAVE_ADDR = 8'h51
) (
    input  logic            pclk_i,
    input  logic            presetn_i,
    spi_slave_sync_if.slave bus
);
    // Counter must also reach 8 for the address frame when DATA_W is small.
    localparam int               MAX_BITS  = (DATA_W > 8) ? DATA_W : 8;
    localparam int               CNT_W     = $clog2(MAX_BITS + 1);
    localparam logic [CNT_W-1:0] WORD_BITS = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0] ADDR_BITS = CNT_W'(8);
    localparam logic             ADDR_FIRST_BIT = LSB_FIRST ? SLAVE_ADDR[0] : SLAVE_ADDR[7];
    localparam logic [7:0]       ADDR_AFTER_FIRST = LSB_FIRST ? (SLAVE_ADDR >> 1) : (SLAVE_ADDR << 1);

    typedef enum logic [2:0] {IDLE, CMD, TX, RX, ADDR} state_t;

    state_t            state_q;
    logic [2:0]        sclkSync_q;
    logic [2:0]        csSync_q;
    logic [1:0]        mosiSync_q;
    logic              leadEdge_q, trailEdge_q, csRise_q, csFall_q;
    logic [CNT_W-1:0]  bitCnt_q;
    logic [DATA_W-1:0] shift_q, txWord_q, rxData_q;
    logic [7:0]        addrShift_q;
    logic              miso_q, rxValid_q, frameErr_q, irqReq_q, irqPend_q;

    logic              sampleEdge, shiftEdge, mosiBit, txReady, irqSet;
    logic [DATA_W-1:0] rxShift_d, txShift_d;
    logic              txBit_d, addrBit_d;
    logic [7:0]        addrShift_d;

    assign sampleEdge  = CPHA ? trailEdge_q : leadEdge_q;
    assign shiftEdge   = CPHA ? leadEdge_q : trailEdge_q;
    assign mosiBit     = mosiSync_q[1];
    assign txReady     = (state_q == IDLE) && !csSync_q[2];
    assign irqSet      = bus.irq_req && !irqReq_q;
    assign rxShift_d   = LSB_FIRST ? {mosiBit, shift_q[DATA_W-1:1]} : {shift_q[DATA_W-2:0], mosiBit};
    assign txBit_d     = LSB_FIRST ? shift_q[0] : shift_q[DATA_W-1];
    assign txShift_d   = LSB_FIRST ? (shift_q >> 1) : (shift_q << 1);
    assign addrBit_d   = LSB_FIRST ? addrShift_q[0] : addrShift_q[7];
    assign addrShift_d = LSB_FIRST ? (addrShift_q >> 1) : (addrShift_q << 1);

    // Stage [1] is the synchronised level, stage [2] its previous value; edges are registered once more.
    always_ff @(posedge pclk_i or negedge presetn_i) begin
        if (!presetn_i) begin
            sclkSync_q  <= {3{CPOL}};
            csSync_q    <= '0;
            mosiSync_q  <= '0;
            leadEdge_q  <= 1'b0;
            trailEdge_q <= 1'b0;
            csRise_q    <= 1'b0;
            csFall_q    <= 1'b0;
        end else begin
            sclkSync_q  <= {sclkSync_q[1:0], bus.sclk};
            csSync_q    <= {csSync_q[1:0], bus.cs};
            mosiSync_q  <= {mosiSync_q[0], bus.mosi};
            leadEdge_q  <= (sclkSync_q[1] != CPOL) && (sclkSync_q[2] == CPOL);
            trailEdge_q <= (sclkSync_q[1] == CPOL) && (sclkSync_q[2] != CPOL);
            csRise_q    <= csSync_q[1] && !csSync_q[2];
            csFall_q    <= !csSync_q[1] && csSync_q[2];
        end
    end

    always_ff @(posedge pclk_i or negedge presetn_i) begin
        if (!presetn_i) begin
            state_q     <= IDLE;
            bitCnt_q    <= '0;
            shift_q     <= '0;
            txWord_q    <= TX_RESET[DATA_W-1:0];
            addrShift_q <= '0;
            miso_q      <= 1'b0;
            rxData_q    <= '0;
            rxValid_q   <= 1'b0;
            frameErr_q  <= 1'b0;
            irqReq_q    <= 1'b0;
            irqPend_q   <= 1'b0;
        end else begin
            rxValid_q  <= 1'b0;
            frameErr_q <= 1'b0;
            irqReq_q   <= bus.irq_req;
            if (irqSet)
                irqPend_q <= 1'b1;
            if (txReady && bus.tx_load)
                txWord_q <= bus.tx_data;

            if (state_q != IDLE && csFall_q) begin
                state_q    <= IDLE;
                bitCnt_q   <= '0;
                frameErr_q <= 1'b1;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (csRise_q) begin
                            bitCnt_q <= '0;
                            if (irqPend_q) begin
                                state_q <= ADDR;
                                // With CPHA=0 the master samples on the first edge, so bit 0 goes out at cs rise.
                                if (CPHA) begin
                                    addrShift_q <= SLAVE_ADDR;
                                end else begin
                                    miso_q      <= ADDR_FIRST_BIT;
                                    addrShift_q <= ADDR_AFTER_FIRST;
                                    bitCnt_q    <= CNT_W'(1);
                                end
                            end else begin
                                state_q <= CMD;
                            end
                        end
                    end
                    CMD: begin
                        if (sampleEdge) begin
                            state_q <= mosiBit ? RX : TX;
                            shift_q <= txWord_q;
                        end
                    end
                    TX: begin
                        if (shiftEdge && bitCnt_q < WORD_BITS) begin
                            miso_q   <= txBit_d;
                            shift_q  <= txShift_d;
                            bitCnt_q <= bitCnt_q + 1'b1;
                        end else if (sampleEdge && bitCnt_q == WORD_BITS) begin
                            state_q  <= IDLE;
                            bitCnt_q <= '0;
                        end
                    end
                    RX: begin
                        if (sampleEdge) begin
                            shift_q <= rxShift_d;
                            if (bitCnt_q == WORD_BITS - 1'b1) begin
                                rxData_q  <= rxShift_d;
                                rxValid_q <= 1'b1;
                                state_q   <= IDLE;
                                bitCnt_q  <= '0;
                            end else begin
                                bitCnt_q <= bitCnt_q + 1'b1;
                            end
                        end
                    end
                    ADDR: begin
                        if (shiftEdge && bitCnt_q < ADDR_BITS) begin
                            miso_q      <= addrBit_d;
                            addrShift_q <= addrShift_d;
                            bitCnt_q    <= bitCnt_q + 1'b1;
                        end else if (sampleEdge && bitCnt_q == ADDR_BITS) begin
                            state_q   <= IDLE;
                            bitCnt_q  <= '0;
                            irqPend_q <= irqSet;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign bus.miso      = miso_q;
    assign bus.miso_oe   = (state_q == TX) || (state_q == ADDR);
    assign bus.tx_ready  = txReady;
    assign bus.rx_data   = rxData_q;
    assign bus.rx_valid  = rxValid_q;
    assign bus.frame_err = frameErr_q;
    assign bus.irq_out   = irqPend_q;
endmodule

// File: tb/tb_spi_slave_sync.sv
// Directed bench: one SPI master model drives five differently parameterised slaves in turn,
// comparing received words and status against hand-computed values.
module tb_spi_slave_sync;
    localparam int HALF = 6;

    logic        pclk;
    logic        presetn;
    logic [2:0]  sel;
    logic        sclkLine, csLine, mosiLine, irqLine, txLoadDrv;
    logic [15:0] txDataDrv;
    logic        selCpol, selCpha;
    logic        curMiso;
    int          assertCnt = 0;
    int          failCnt = 0;
    int          rxValidCnt0 = 0;
    int          frameErrCnt0 = 0;
    int          oeCnt0 = 0;

    spi_slave_sync_if #(.DATA_W(8))  if0 ();
    spi_slave_sync_if #(.DATA_W(8))  if1 ();
    spi_slave_sync_if #(.DATA_W(8))  if2 ();
    spi_slave_sync_if #(.DATA_W(8))  if3 ();
    spi_slave_sync_if #(.DATA_W(16)) if16 ();

    spi_slave_sync #(.DATA_W(8), .CPOL(1'b0), .CPHA(1'b0), .LSB_FIRST(1'b1))
        dut0 (.pclk_i(pclk), .presetn_i(presetn), .bus(if0));
    spi_slave_sync #(.DATA_W(8), .CPOL(1'b0), .CPHA(1'b1), .LSB_FIRST(1'b1))
        dut1 (.pclk_i(pclk), .presetn_i(presetn), .bus(if1));
    spi_slave_sync #(.DATA_W(8), .CPOL(1'b1), .CPHA(1'b0), .LSB_FIRST(1'b1))
        dut2 (.pclk_i(pclk), .presetn_i(presetn), .bus(if2));
    spi_slave_sync #(.DATA_W(8), .CPOL(1'b1), .CPHA(1'b1), .LSB_FIRST(1'b1))
        dut3 (.pclk_i(pclk), .presetn_i(presetn), .bus(if3));
    spi_slave_sync #(.DATA_W(16), .CPOL(1'b0), .CPHA(1'b0), .LSB_FIRST(1'b0), .TX_RESET(32'h0000_00ab))
        dut16 (.pclk_i(pclk), .presetn_i(presetn), .bus(if16));

    // Only the selected slave sees the bus; the others sit at their idle sclk level with cs low.
    assign if0.sclk     = (sel == 3'd0) ? sclkLine : 1'b0;
    assign if1.sclk     = (sel == 3'd1) ? sclkLine : 1'b0;
    assign if2.sclk     = (sel == 3'd2) ? sclkLine : 1'b1;
    assign if3.sclk     = (sel == 3'd3) ? sclkLine : 1'b1;
    assign if16.sclk    = (sel == 3'd4) ? sclkLine : 1'b0;
    assign if0.cs       = (sel == 3'd0) && csLine;
    assign if1.cs       = (sel == 3'd1) && csLine;
    assign if2.cs       = (sel == 3'd2) && csLine;
    assign if3.cs       = (sel == 3'd3) && csLine;
    assign if16.cs      = (sel == 3'd4) && csLine;
    assign if0.tx_load  = (sel == 3'd0) && txLoadDrv;
    assign if1.tx_load  = (sel == 3'd1) && txLoadDrv;
    assign if2.tx_load  = (sel == 3'd2) && txLoadDrv;
    assign if3.tx_load  = (sel == 3'd3) && txLoadDrv;
    assign if16.tx_load = (sel == 3'd4) && txLoadDrv;
    assign if0.mosi     = mosiLine;
    assign if1.mosi     = mosiLine;
    assign if2.mosi     = mosiLine;
    assign if3.mosi     = mosiLine;
    assign if16.mosi    = mosiLine;
    assign if0.tx_data  = txDataDrv[7:0];
    assign if1.tx_data  = txDataDrv[7:0];
    assign if2.tx_data  = txDataDrv[7:0];
    assign if3.tx_data  = txDataDrv[7:0];
    assign if16.tx_data = txDataDrv;
    assign if0.irq_req  = irqLine;
    assign if1.irq_req  = 1'b0;
    assign if2.irq_req  = 1'b0;
    assign if3.irq_req  = 1'b0;
    assign if16.irq_req = 1'b0;

    always_comb begin
        case (sel)
            3'd1:    curMiso = if1.miso;
            3'd2:    curMiso = if2.miso;
            3'd3:    curMiso = if3.miso;
            3'd4:    curMiso = if16.miso;
            default: curMiso = if0.miso;
        endcase
    end

    initial begin
        pclk = 1'b0;
        forever #5 pclk = ~pclk;
    end

    // Pulse and drive-enable counters for the mode-0 slave, sampled mid-cycle.
    always @(negedge pclk) begin
        if (if0.rx_valid)  rxValidCnt0  <= rxValidCnt0 + 1;
        if (if0.frame_err) frameErrCnt0 <= frameErrCnt0 + 1;
        if (if0.miso_oe)   oeCnt0       <= oeCnt0 + 1;
    end

    initial begin
        #500000;
        $display("[TB] FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "[TB] timeout");
    end

    task automatic waitCycles(input int n);
        repeat (n) @(negedge pclk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        assertCnt++;
        if (got !== exp) begin
            failCnt++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Bit sequence on the wire: optional command bit first, then the word in transfer order.
    function automatic logic [32:0] buildSeq(input bit hasCmd, input logic cmd, input logic [31:0] word,
                                             input int w, input bit lsbFirst);
        logic [32:0] s;
        int          off;
        s   = '0;
        off = hasCmd ? 1 : 0;
        if (hasCmd) s[0] = cmd;
        for (int i = 0; i < w; i++)
            s[off + i] = lsbFirst ? word[i] : word[w - 1 - i];
        return s;
    endfunction

    function automatic logic [31:0] seqToWord(input logic [32:0] s, input int off, input int w, input bit lsbFirst);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < w; i++) begin
            if (lsbFirst) r[i] = s[off + i];
            else          r[w - 1 - i] = s[off + i];
        end
        return r;
    endfunction

    task automatic selectDut(input logic [2:0] k, input logic cpol, input logic cpha);
        waitCycles(1);
        selCpol  = cpol;
        selCpha  = cpha;
        sclkLine = cpol;
        sel      = k;
        waitCycles(4);
    endtask

    task automatic loadWord(input logic [15:0] w);
        txDataDrv = w;
        txLoadDrv = 1'b1;
        waitCycles(1);
        txLoadDrv = 1'b0;
        waitCycles(1);
    endtask

    // One SPI frame of nbits sclk periods; miso is captured on the master's sample edge.
    task automatic applyStimulus(input int nbits, input logic [32:0] mosiSeq, output logic [32:0] misoSeq);
        misoSeq = '0;
        csLine  = 1'b1;
        waitCycles(HALF);
        for (int i = 0; i < nbits; i++) begin
            if (!selCpha) begin
                mosiLine = mosiSeq[i];
                waitCycles(HALF);
                sclkLine   = ~selCpol;
                misoSeq[i] = curMiso;
                waitCycles(HALF);
                sclkLine = selCpol;
            end else begin
                sclkLine = ~selCpol;
                mosiLine = mosiSeq[i];
                waitCycles(HALF);
                sclkLine   = selCpol;
                misoSeq[i] = curMiso;
                waitCycles(HALF);
            end
        end
        waitCycles(HALF);
        csLine   = 1'b0;
        mosiLine = 1'b0;
        waitCycles(2 * HALF);
    endtask

    initial begin
        logic [32:0] mi;
        int          rxBase, errBase, oeBase;

        presetn   = 1'b1;
        sel       = 3'd0;
        selCpol   = 1'b0;
        selCpha   = 1'b0;
        sclkLine  = 1'b0;
        csLine    = 1'b0;
        mosiLine  = 1'b0;
        irqLine   = 1'b0;
        txLoadDrv = 1'b0;
        txDataDrv = '0;
        #2 presetn = 1'b0;
        waitCycles(3);
        checkOutput("reset_miso", if0.miso, 0);
        checkOutput("reset_miso_oe", if0.miso_oe, 0);
        checkOutput("reset_rx_data", if0.rx_data, 0);
        checkOutput("reset_rx_valid", if0.rx_valid, 0);
        checkOutput("reset_frame_err", if0.frame_err, 0);
        checkOutput("reset_irq_out", if0.irq_out, 0);
        presetn = 1'b1;
        waitCycles(4);
        checkOutput("idle_tx_ready", if0.tx_ready, 1);

        $display("[TB] RX word, mode 0");
        rxBase = rxValidCnt0; errBase = frameErrCnt0; oeBase = oeCnt0;
        applyStimulus(9, buildSeq(1'b1, 1'b1, 32'hC3, 8, 1'b1), mi);
        checkOutput("rx_data_c3", if0.rx_data, 32'hC3);
        checkOutput("rx_valid_once", rxValidCnt0 - rxBase, 1);
        checkOutput("rx_no_frame_err", frameErrCnt0 - errBase, 0);
        checkOutput("rx_miso_oe_low", oeCnt0 - oeBase, 0);

        $display("[TB] TX word in modes 3, 1, 2");
        selectDut(3'd3, 1'b1, 1'b1);
        applyStimulus(9, buildSeq(1'b1, 1'b0, 32'h0, 8, 1'b1), mi);
        checkOutput("tx_mode3_reset_word", seqToWord(mi, 1, 8, 1'b1), 32'hAB);
        checkOutput("mode3_tx_ready", if3.tx_ready, 1);
        loadWord(16'h005A);
        applyStimulus(9, buildSeq(1'b1, 1'b0, 32'h0, 8, 1'b1), mi);
        checkOutput("tx_mode3_loaded", seqToWord(mi, 1, 8, 1'b1), 32'h5A);
        selectDut(3'd1, 1'b0, 1'b1);
        loadWord(16'h005A);
        applyStimulus(9, buildSeq(1'b1, 1'b0, 32'h0, 8, 1'b1), mi);
        checkOutput("tx_mode1_loaded", seqToWord(mi, 1, 8, 1'b1), 32'h5A);
        selectDut(3'd2, 1'b1, 1'b0);
        loadWord(16'h005A);
        applyStimulus(9, buildSeq(1'b1, 1'b0, 32'h0, 8, 1'b1), mi);
        checkOutput("tx_mode2_loaded", seqToWord(mi, 1, 8, 1'b1), 32'h5A);

        $display("[TB] 16-bit MSB-first slave");
        selectDut(3'd4, 1'b0, 1'b0);
        applyStimulus(17, buildSeq(1'b1, 1'b1, 32'hBEEF, 16, 1'b0), mi);
        checkOutput("rx16_beef", if16.rx_data, 32'hBEEF);
        loadWord(16'h1234);
        applyStimulus(17, buildSeq(1'b1, 1'b0, 32'h0, 16, 1'b0), mi);
        checkOutput("tx16_1234", seqToWord(mi, 1, 16, 1'b0), 32'h1234);

        $display("[TB] Interrupt frame");
        selectDut(3'd0, 1'b0, 1'b0);
        rxBase = rxValidCnt0;
        fork
            applyStimulus(9, buildSeq(1'b1, 1'b1, 32'h3C, 8, 1'b1), mi);
            begin
                waitCycles(40);
                irqLine = 1'b1;
            end
        join
        checkOutput("irq_rx_data", if0.rx_data, 32'h3C);
        checkOutput("irq_rx_valid_once", rxValidCnt0 - rxBase, 1);
        checkOutput("irq_out_pending", if0.irq_out, 1);
        applyStimulus(8, 33'h0, mi);
        checkOutput("addr_frame_51", seqToWord(mi, 0, 8, 1'b1), 32'h51);
        checkOutput("irq_out_cleared", if0.irq_out, 0);
        irqLine = 1'b0;
        waitCycles(4);

        $display("[TB] Abort after 3 RX bits");
        rxBase = rxValidCnt0; errBase = frameErrCnt0;
        applyStimulus(4, buildSeq(1'b1, 1'b1, 32'hFF, 8, 1'b1), mi);
        checkOutput("abort_frame_err", frameErrCnt0 - errBase, 1);
        checkOutput("abort_no_rx_valid", rxValidCnt0 - rxBase, 0);
        checkOutput("abort_rx_data_kept", if0.rx_data, 32'h3C);
        applyStimulus(9, buildSeq(1'b1, 1'b1, 32'h0F, 8, 1'b1), mi);
        checkOutput("after_abort_rx_0f", if0.rx_data, 32'h0F);

        $display("[TB] Reset mid-TX and load gating");
        loadWord(16'h005A);
        fork
            applyStimulus(9, buildSeq(1'b1, 1'b0, 32'h0, 8, 1'b1), mi);
            begin
                waitCycles(50);
                checkOutput("oe_before_reset", if0.miso_oe, 1);
                presetn = 1'b0;
                #1;
                checkOutput("reset_mid_tx_oe", if0.miso_oe, 0);
                checkOutput("reset_mid_tx_rx_data", if0.rx_data, 0);
            end
        join
        waitCycles(2);
        presetn = 1'b1;
        waitCycles(4);
        applyStimulus(9, buildSeq(1'b1, 1'b0, 32'h0, 8, 1'b1), mi);
        checkOutput("tx_after_reset_ab", seqToWord(mi, 1, 8, 1'b1), 32'hAB);
        errBase = frameErrCnt0;
        csLine = 1'b1;
        waitCycles(8);
        checkOutput("cs_high_tx_ready", if0.tx_ready, 0);
        loadWord(16'h0077);
        csLine = 1'b0;
        waitCycles(10);
        checkOutput("empty_frame_err", frameErrCnt0 - errBase, 1);
        applyStimulus(9, buildSeq(1'b1, 1'b0, 32'h0, 8, 1'b1), mi);
        checkOutput("gated_load_ignored", seqToWord(mi, 1, 8, 1'b1), 32'hAB);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCnt, failCnt);
        $finish;
    end
endmodule
